// File: rtl/l1_miss_handler.sv
// L1 miss fill engine: per-port pending slots, round-robin pick, a single BRAM read in
// flight, and a fill written into the cache entry named by a cyclic victim pointer.
`ifndef CHUNK_WIDTH
`define CHUNK_WIDTH 16
`endif

module l1_mh_slot #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cap_i,
  input  logic [AW-1:0] addr_i,
  input  logic          clr_i,
  output logic          pend_o,
  output logic [AW-1:0] addr_o
);
  logic          pend_q;
  logic [AW-1:0] addr_q;

  // A clear always beats a capture on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      addr_q <= '0;
    end else if (clr_i) begin
      pend_q <= 1'b0;
    end else if (cap_i) begin
      pend_q <= 1'b1;
      addr_q <= addr_i;
    end
  end

  assign pend_o = pend_q;
  assign addr_o = addr_q;
endmodule

module l1_miss_handler #(
  parameter int                 PORTS       = 4,
  parameter int                 CACHE_SIZE  = 16,
  parameter int                 MEM_LATENCY = 2,
  parameter int                 BLOCK_W     = 16,
  parameter logic [BLOCK_W-1:0] BLOCK_AIR   = '0,
  localparam int CW = `CHUNK_WIDTH,
  localparam int CB = $clog2(CW),
  localparam int AW = 3 * CB,
  localparam int TB = $clog2(CACHE_SIZE),
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1,
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [PORTS-1:0]          miss_valid,
  input  logic [PORTS-1:0][AW-1:0]  miss_addr,
  output logic [PORTS-1:0]          miss_ready,
  output logic                      mem_rd,
  output logic [AW-1:0]             mem_addr,
  input  logic [BLOCK_W-1:0]        mem_data,
  output logic                      fill_valid,
  output logic [TB-1:0]             fill_idx,
  output logic [AW-1:0]             fill_tag,
  output logic [BLOCK_W-1:0]        fill_data,
  output logic                      busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FILL} state_t;

  // Most-negative coordinate marks an invalid tag; flipping each MSB gives offset binary.
  localparam logic [CB-1:0] NEG  = {1'b1, {(CB-1){1'b0}}};
  localparam logic [AW-1:0] MSBS = {3{NEG}};

  state_t               state_q, state_d;
  logic [AW-1:0]        cur_q, cur_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [TB-1:0]        victim_q, victim_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [BLOCK_W-1:0]   data_q, data_d;

  logic [PORTS-1:0]          pend, cap, clr;
  logic [PORTS-1:0][AW-1:0]  slot_addr;
  logic [PW-1:0]             win, cand;
  logic                      found, any_pend;

  assign any_pend = |pend;
  assign busy     = (state_q != S_IDLE) | any_pend;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    logic hit_pend, invalid, inflight, ready;

    always_comb begin
      hit_pend = 1'b0;
      for (int j = 0; j < PORTS; j++)
        if (pend[j] && slot_addr[j] == miss_addr[i]) hit_pend = 1'b1;
    end

    assign invalid  = (miss_addr[i][AW-1 -: CB] == NEG) |
                      (miss_addr[i][2*CB-1 -: CB] == NEG) |
                      (miss_addr[i][CB-1:0] == NEG);
    assign inflight = (state_q != S_IDLE) && (miss_addr[i] == cur_q);
    assign clr[i]   = (state_q == S_FILL) && pend[i] && (slot_addr[i] == cur_q);
    // A slot being cleared can only take a miss that merges into the fill in progress.
    assign ready         = ~pend[i] | (clr[i] & (miss_addr[i] == cur_q));
    assign miss_ready[i] = ready & ~rst_in;
    assign cap[i]        = miss_valid[i] & ready & ~invalid & ~hit_pend & ~inflight;

    l1_mh_slot #(.AW(AW)) u_slot (
      .clk_i  (clk_in),
      .rst_i  (rst_in),
      .cap_i  (cap[i]),
      .addr_i (miss_addr[i]),
      .clr_i  (clr[i]),
      .pend_o (pend[i]),
      .addr_o (slot_addr[i])
    );
  end

  always_comb begin
    win   = rr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      cand = PW'((int'(rr_q) + k) % PORTS);
      if (!found && pend[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      cnt_q    <= '0;
      victim_q <= '0;
      rr_q     <= '0;
      data_q   <= BLOCK_AIR;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      rr_q     <= rr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    victim_d   = victim_q;
    rr_d       = rr_q;
    data_d     = data_q;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    fill_valid = 1'b0;
    fill_idx   = '0;
    fill_tag   = '0;
    fill_data  = BLOCK_AIR;
    unique case (state_q)
      S_IDLE: if (any_pend) begin
        state_d = S_ISSUE;
        cur_d   = slot_addr[win];
        rr_d    = (win == PW'(PORTS - 1)) ? '0 : win + 1'b1;
      end
      S_ISSUE: begin
        mem_rd   = 1'b1;
        mem_addr = cur_q ^ MSBS;
        cnt_d    = LW'(MEM_LATENCY - 1);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = mem_data;
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FILL: begin
        fill_valid = 1'b1;
        fill_idx   = victim_q;
        fill_tag   = cur_q;
        fill_data  = data_q;
        victim_d   = (victim_q == TB'(CACHE_SIZE - 1)) ? '0 : victim_q + 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
